// File: rtl/MiniLab_defs.sv
// Shared definitions for the MiniLab bitmap display path: field widths,
// the command scheduler state encoding and the queued command entry layout.
package MiniLab_defs;

    localparam int BMP_X_W     = 10;
    localparam int BMP_Y_W     = 9;
    localparam int BMP_CMD_W   = 8;
    localparam int BMP_ENTRY_W = BMP_X_W + BMP_Y_W + BMP_CMD_W;

    // Cycles spent in S_WAIT_ACK before a command that never made the
    // display busy is treated as complete.
    localparam int ACK_TIMEOUT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_X,
        S_LD_Y,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } bmp_sched_state_t;

    // One queued display command, X in the top bits.
    typedef struct packed {
        logic [BMP_X_W-1:0]   x;
        logic [BMP_Y_W-1:0]   y;
        logic [BMP_CMD_W-1:0] cmd;
    } bmp_entry_t;

endpackage

// File: rtl/bmp_cmd_fifo.sv
// Circular command queue for the bitmap scheduler. The head entry is
// presented combinationally on dout; a push into a full queue is accepted
// only when a pop happens on the same edge.
module bmp_cmd_fifo
    import MiniLab_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [BMP_ENTRY_W-1:0] din,
    input  logic                   pop,
    output logic [BMP_ENTRY_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [BMP_ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   push_ok;
    logic                   pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: state is updated with <= so every register samples the
            // pre-edge values regardless of statement order.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the array has no reset; cleared pointers make stale contents
    // unreachable, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bmp_cmd_sched.sv
// Bitmap display command scheduler: stages X/Y from the host, queues
// {X, Y, cmd} entries and replays each one to the display as an X write,
// a Y write and a command write, then waits for the display to finish.
module bmp_cmd_sched
    import MiniLab_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_wr,
    input  logic [BMP_X_W-1:0]     x_wdata,
    input  logic                   y_wr,
    input  logic [BMP_Y_W-1:0]     y_wdata,
    input  logic                   cmd_wr,
    input  logic [BMP_CMD_W-1:0]   cmd_wdata,
    input  logic                   clr_ovf,
    output logic                   q_full,
    output logic                   q_empty,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   busy,
    output logic                   overflow,
    output logic [BMP_X_W-1:0]     bmp_x_pos,
    output logic                   bmp_x_we,
    output logic [BMP_Y_W-1:0]     bmp_y_pos,
    output logic                   bmp_y_we,
    output logic [BMP_CMD_W-1:0]   bmp_cmd,
    output logic                   bmp_cmd_we,
    input  logic                   bmp_idle
);

    localparam logic [1:0] ACK_LAST = 2'(ACK_TIMEOUT - 1);

    bmp_sched_state_t state;
    bmp_sched_state_t state_nx;

    logic [BMP_X_W-1:0] stage_x;
    logic [BMP_Y_W-1:0] stage_y;
    bmp_entry_t         push_ent;
    bmp_entry_t         head_ent;
    bmp_entry_t         hold_ent;
    logic               pop_go;
    logic               drop;
    logic [1:0]         ack_cnt;
    logic               ovf_q;
    logic               x_we_q;
    logic               y_we_q;
    logic               cmd_we_q;

    // Same-cycle host writes bypass the staging registers into the push.
    assign push_ent = {(x_wr ? x_wdata : stage_x),
                       (y_wr ? y_wdata : stage_y),
                       cmd_wdata};

    // The head leaves the queue only from S_IDLE with a free display.
    assign pop_go = (state == S_IDLE) && !q_empty && bmp_idle;
    assign drop   = cmd_wr && q_full && !pop_go;

    bmp_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_wr),
        .din   (push_ent),
        .pop   (pop_go),
        .dout  (head_ent),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level)
    );

    // Staging registers hold the last host-written X and Y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_x <= '0;
            stage_y <= '0;
        end else begin
            if (x_wr) stage_x <= x_wdata;
            if (y_wr) stage_y <= y_wdata;
        end
    end

    // Sticky overflow: a dropped push outranks a clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Counts cycles spent waiting for the display to acknowledge a command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state == S_WAIT_ACK) begin
            ack_cnt <= ack_cnt + 1'b1;
        end else begin
            ack_cnt <= '0;
        end
    end

    // Next-state decode for one X / Y / command replay.
    always_comb begin
        // NOTE: defaulting the target first keeps every path assigned, so no
        // latch is inferred for states or conditions that do not move.
        state_nx = state;
        case (state)
            S_IDLE:      if (pop_go) state_nx = S_LD_X;
            S_LD_X:      state_nx = S_LD_Y;
            S_LD_Y:      state_nx = S_ISSUE;
            S_ISSUE:     state_nx = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bmp_idle)                state_nx = S_WAIT_DONE;
                else if (ack_cnt == ACK_LAST) state_nx = S_IDLE;
            end
            S_WAIT_DONE: if (bmp_idle) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Hold registers capture the head entry as it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         hold_ent <= '0;
        else if (pop_go) hold_ent <= head_ent;
    end

    // Strobes are registered from the next state so each one is high for
    // exactly the cycle its load state occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_we_q   <= 1'b0;
            y_we_q   <= 1'b0;
            cmd_we_q <= 1'b0;
        end else begin
            x_we_q   <= (state_nx == S_LD_X);
            y_we_q   <= (state_nx == S_LD_Y);
            cmd_we_q <= (state_nx == S_ISSUE);
        end
    end

    assign busy       = (state != S_IDLE) || !q_empty;
    assign overflow   = ovf_q;
    assign bmp_x_pos  = hold_ent.x;
    assign bmp_y_pos  = hold_ent.y;
    assign bmp_cmd    = hold_ent.cmd;
    assign bmp_x_we   = x_we_q;
    assign bmp_y_we   = y_we_q;
    assign bmp_cmd_we = cmd_we_q;

endmodule

// File: tb/tb_bmp_cmd_sched.sv
// Self-checking bench for bmp_cmd_sched: directed scenarios plus a random
// phase, all compared every cycle against a transaction-level model.
module tb_bmp_cmd_sched;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          x_wr, y_wr, cmd_wr, clr_ovf;
    logic [9:0]    x_wdata;
    logic [8:0]    y_wdata;
    logic [7:0]    cmd_wdata;
    logic          q_full, q_empty, busy, overflow;
    logic [LW-1:0] q_level;
    logic [9:0]    bmp_x_pos;
    logic [8:0]    bmp_y_pos;
    logic [7:0]    bmp_cmd;
    logic          bmp_x_we, bmp_y_we, bmp_cmd_we;
    logic          bmp_idle;

    bmp_cmd_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .x_wr(x_wr), .x_wdata(x_wdata), .y_wr(y_wr), .y_wdata(y_wdata),
        .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata), .clr_ovf(clr_ovf),
        .q_full(q_full), .q_empty(q_empty), .q_level(q_level),
        .busy(busy), .overflow(overflow),
        .bmp_x_pos(bmp_x_pos), .bmp_x_we(bmp_x_we),
        .bmp_y_pos(bmp_y_pos), .bmp_y_we(bmp_y_we),
        .bmp_cmd(bmp_cmd), .bmp_cmd_we(bmp_cmd_we), .bmp_idle(bmp_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] c;
    } ent_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of accepted entries; a replay is tracked by edges since its pop:
    // X strobe after pop edge 0, Y after 1, command after 2, then the wait
    // window opens (display ack on edges 4..7, else done at edge 7).
    ent_t       m_q[$];
    logic [9:0] m_sx;
    logic [8:0] m_sy;
    bit         m_ovf;
    bit         m_free;
    int         m_t;
    bit         m_acked;
    ent_t       m_hold;
    bit         m_last_idle;

    int   cyc = 0;
    int   idle_cnt = 0;
    int   disp_lat = 0;
    bit   hold_busy = 0;
    bit   rand_lat = 0;
    int   x_caps[$];
    int   c_caps[$];
    logic [9:0] x_pos_cap;
    logic [8:0] y_pos_cap;
    logic [7:0] issued[$];
    int   cmd_cnt = 0;

    task automatic model_reset();
        m_q.delete();
        m_sx = '0; m_sy = '0; m_ovf = 0;
        m_free = 1; m_t = 0; m_acked = 0; m_hold = '0;
    endtask

    task automatic model_edge();
        bit   pop, acc;
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        m_last_idle = bmp_idle;
        pop = m_free && (m_q.size() > 0) && bmp_idle;
        e.x = x_wr ? x_wdata : m_sx;
        e.y = y_wr ? y_wdata : m_sy;
        e.c = cmd_wdata;
        acc = cmd_wr && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            m_hold = m_q.pop_front();
            m_free = 0; m_t = 0; m_acked = 0;
        end else if (!m_free) begin
            m_t++;
            if (m_t >= 4) begin
                if (m_acked) begin
                    if (bmp_idle) m_free = 1;
                end else if (!bmp_idle) begin
                    m_acked = 1;
                end else if (m_t == 7) begin
                    m_free = 1;
                end
            end
        end
        if (acc) m_q.push_back(e);
        if (cmd_wr && !acc) m_ovf = 1;
        else if (clr_ovf)   m_ovf = 0;
        if (x_wr) m_sx = x_wdata;
        if (y_wr) m_sy = y_wdata;
    endtask

    task automatic compare_outputs();
        check("q_level",  32'(q_level),  32'(m_q.size()));
        check("q_full",   32'(q_full),   32'(m_q.size() == DEPTH));
        check("q_empty",  32'(q_empty),  32'(m_q.size() == 0));
        check("busy",     32'(busy),     32'(!m_free || m_q.size() > 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("x_we",     32'(bmp_x_we), 32'(!m_free && m_t == 0));
        check("y_we",     32'(bmp_y_we), 32'(!m_free && m_t == 1));
        check("cmd_we",   32'(bmp_cmd_we), 32'(!m_free && m_t == 2));
        check("x_pos",    32'(bmp_x_pos), 32'(m_hold.x));
        check("y_pos",    32'(bmp_y_pos), 32'(m_hold.y));
        check("cmd",      32'(bmp_cmd),   32'(m_hold.c));
    endtask

    task automatic update_idle();
        bmp_idle = !(hold_busy || idle_cnt > 0);
    endtask

    // One clock: model steps on the edge, outputs are sampled on the falling
    // edge, the display model reacts, and one-shot host pulses are cleared.
    // A strobe seen after edge k is captured by the display at edge k+1.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_outputs();
        if (bmp_x_we) begin
            x_caps.push_back(cyc + 1);
            x_pos_cap = bmp_x_pos;
            check("pop_with_display_busy", 32'(m_last_idle), 32'd1);
        end
        if (bmp_y_we) y_pos_cap = bmp_y_pos;
        if (bmp_cmd_we) begin
            c_caps.push_back(cyc + 1);
            issued.push_back(bmp_cmd);
            cmd_cnt++;
            idle_cnt = rand_lat ? int'($urandom_range(0, 12)) : disp_lat;
        end else if (idle_cnt > 0) begin
            idle_cnt--;
        end
        update_idle();
        x_wr = 0; y_wr = 0; cmd_wr = 0; clr_ovf = 0;
    endtask

    task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [7:0] c,
                        input bit wx, input bit wy);
        x_wr = wx; x_wdata = x;
        y_wr = wy; y_wdata = y;
        cmd_wr = 1; cmd_wdata = c;
        tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy || !bmp_idle) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        #2;
        rst = 1;
        model_reset();
        idle_cnt = 0; hold_busy = 0;
        update_idle();
        #1;
        compare_outputs();
        repeat (cycles) tick();
        rst = 0;
    endtask

    initial begin
        int n0, n;
        rst = 1; x_wr = 0; y_wr = 0; cmd_wr = 0; clr_ovf = 0;
        x_wdata = '0; y_wdata = '0; cmd_wdata = '0; bmp_idle = 1;
        model_reset();
        #1;
        compare_outputs();
        tick(); tick();
        rst = 0;
        tick();
        check("rst_q_empty", 32'(q_empty), 32'd1);
        check("rst_q_full",  32'(q_full),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);

        // Basic latency: staged X/Y, then a command pushed at edge N.
        x_wr = 1; x_wdata = 10'h155; tick();
        y_wr = 1; y_wdata = 9'h0AA;  tick();
        x_caps.delete(); c_caps.delete();
        cmd_wr = 1; cmd_wdata = 8'h03; tick();
        n0 = cyc;
        drain(50);
        check("lat_x_cap",   32'(x_caps[0]), 32'(n0 + 2));
        check("lat_cmd_cap", 32'(c_caps[0]), 32'(n0 + 4));
        check("lat_x_pos",   32'(x_pos_cap), 32'h155);
        check("lat_y_pos",   32'(y_pos_cap), 32'h0AA);
        check("lat_cmd",     32'(issued[issued.size()-1]), 32'h03);

        // Overflow: five pushes into a 4-deep queue with the display busy.
        hold_busy = 1; update_idle();
        issued.delete();
        for (int i = 0; i < 5; i++) push(10'(i), 9'(i), 8'h40 + 8'(i), 1, 1);
        check("ovf_full",  32'(q_full),   32'd1);
        check("ovf_level", 32'(q_level),  32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        clr_ovf = 1; tick();
        check("ovf_clear", 32'(overflow), 32'd0);
        hold_busy = 0; disp_lat = 0; update_idle();
        drain(200);
        check("ovf_issued_cnt", 32'(issued.size()), 32'd4);
        check("ovf_last_kept",  32'(issued[3]),     32'h43);

        // In-order issue with a display busy for 10 cycles per command.
        disp_lat = 10; issued.delete();
        push(10'h011, 9'h011, 8'h11, 1, 1);
        push(10'h022, 9'h022, 8'h22, 1, 1);
        push(10'h033, 9'h033, 8'h33, 1, 1);
        drain(300);
        check("order_cnt", 32'(issued.size()), 32'd3);
        check("order_0",   32'(issued[0]),     32'h11);
        check("order_1",   32'(issued[1]),     32'h22);
        check("order_2",   32'(issued[2]),     32'h33);

        // Same-cycle staging bypass, then the staged value must persist.
        disp_lat = 0;
        x_wr = 1; x_wdata = 10'h001; tick();
        y_wr = 1; y_wdata = 9'h002;  tick();
        push(10'h3FF, 9'h1FF, 8'h5A, 1, 1);
        drain(50);
        check("bypass_x", 32'(x_pos_cap), 32'h3FF);
        check("bypass_y", 32'(y_pos_cap), 32'h1FF);
        push(10'h000, 9'h000, 8'h5B, 0, 0);
        drain(50);
        check("stage_hold_x", 32'(x_pos_cap), 32'h3FF);
        check("stage_hold_y", 32'(y_pos_cap), 32'h1FF);

        // Display never goes busy: ack window times out, next entry follows.
        disp_lat = 0; x_caps.delete(); c_caps.delete();
        push(10'h100, 9'h100, 8'h61, 1, 1);
        push(10'h101, 9'h101, 8'h62, 1, 1);
        drain(100);
        check("timeout_gap", 32'(x_caps[1] - c_caps[0]), 32'd6);

        // Reset in S_LD_Y with two entries still queued.
        hold_busy = 1; update_idle();
        push(10'h071, 9'h071, 8'h71, 1, 1);
        push(10'h072, 9'h072, 8'h72, 1, 1);
        push(10'h073, 9'h073, 8'h73, 1, 1);
        hold_busy = 0; update_idle();
        n = 0;
        while (!bmp_y_we && n < 20) begin tick(); n++; end
        check("rstmid_reach_ld_y", 32'(bmp_y_we), 32'd1);
        check("rstmid_queued",     32'(q_level),  32'd2);
        n0 = cmd_cnt;
        apply_reset(2);
        check("rstmid_x_pos",  32'(bmp_x_pos), 32'd0);
        check("rstmid_y_we",   32'(bmp_y_we),  32'd0);
        repeat (10) tick();
        check("rstmid_no_cmd", 32'(cmd_cnt - n0), 32'd0);
        check("rstmid_empty",  32'(q_empty),      32'd1);
        check("rstmid_cmd",    32'(bmp_cmd),      32'd0);

        // Random traffic against the model.
        rand_lat = 1;
        for (int i = 0; i < 600; i++) begin
            x_wr = ($urandom_range(0, 99) < 20); x_wdata = 10'($urandom_range(0, 1023));
            y_wr = ($urandom_range(0, 99) < 20); y_wdata = 9'($urandom_range(0, 511));
            cmd_wr = ($urandom_range(0, 99) < 30); cmd_wdata = 8'($urandom_range(0, 255));
            clr_ovf = ($urandom_range(0, 99) < 5);
            tick();
        end
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
